// File: rtl/gp_accum_blk_if.sv
// Sample-in / block-result-out bundle for gp_accum_blk.
// The block takes the slave side; the producer/consumer takes master.
interface gp_accum_blk_if #(
    parameter int DW = 3,
    parameter int AW = 6,
    parameter int CW = 4
);
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data1;
    logic [DW-1:0] i_data2;
    logic [1:0]    i_sel;
    logic          i_sub;
    logic          i_sat;
    logic [CW-1:0] i_len;
    logic          i_clear;
    logic [AW-1:0] o_acc;
    logic          o_valid;
    logic          i_ready;
    logic [AW-1:0] o_data;
    logic          o_overflow;

    modport master (
        output i_valid, i_data1, i_data2, i_sel, i_sub, i_sat, i_len, i_clear, i_ready,
        input  o_ready, o_acc, o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_data1, i_data2, i_sel, i_sub, i_sat, i_len, i_clear, i_ready,
        output o_ready, o_acc, o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/gp_accum_blk.sv
// Block accumulator: select/add-or-subtract into a running acc, emit the
// block result after a programmable sample count, stall input until taken.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_ACC  | accepting samples, accumulating the current block
// ST_HOLD | block result presented on o_data, input stalled until taken
module gp_accum_blk #(
    parameter int DW = 3,
    parameter int AW = 6,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          i_rst_n,
    gp_accum_blk_if.slave bus
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] len_q, len_d;
    logic          sticky_q, sticky_d;
    logic [AW-1:0] data_q, data_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;

    logic [DW:0]   opnd;
    logic [AW:0]   op_ext;
    logic [AW:0]   acc_ext;
    logic [AW:0]   res;
    logic          res_ovf;
    logic [AW-1:0] acc_new;
    logic [CW-1:0] len_cur;
    logic          last;

    // Datapath: carry/borrow out of the AW+1 bit result is the overflow flag.
    always_comb begin
        opnd = '0;
        case (bus.i_sel)
            2'b00:   opnd = {1'b0, bus.i_data2};
            2'b01:   opnd = {1'b0, bus.i_data1} + {1'b0, bus.i_data2};
            2'b10:   opnd = {1'b0, bus.i_data1};
            default: opnd = '0;
        endcase
        op_ext  = {{(AW-DW){1'b0}}, opnd};
        acc_ext = {1'b0, acc_q};
        res     = bus.i_sub ? (acc_ext - op_ext) : (acc_ext + op_ext);
        res_ovf = res[AW];
        if (res_ovf && bus.i_sat) begin
            acc_new = bus.i_sub ? {AW{1'b0}} : {AW{1'b1}};
        end else begin
            acc_new = res[AW-1:0];
        end
        // Length of 0 wraps to all-ones here, i.e. 2^CW samples.
        len_cur = (count_q == '0) ? bus.i_len : len_q;
        last    = (count_q == (len_cur - CW'(1)));
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        len_d    = len_q;
        sticky_d = sticky_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        case (state_q)
            ST_ACC: begin
                if (bus.i_clear) begin
                    acc_d    = '0;
                    count_d  = '0;
                    sticky_d = 1'b0;
                end else if (bus.i_valid) begin
                    if (count_q == '0) begin
                        len_d = bus.i_len;
                    end
                    if (last) begin
                        data_d   = acc_new;
                        ovf_d    = sticky_q | res_ovf;
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        count_d  = '0;
                        sticky_d = 1'b0;
                        state_d  = ST_HOLD;
                    end else begin
                        acc_d    = acc_new;
                        count_d  = count_q + CW'(1);
                        sticky_d = sticky_q | res_ovf;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_ACC;
            acc_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            len_q    <= len_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_ready    = (state_q == ST_ACC);
    assign bus.o_acc      = acc_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_gp_accum_blk.sv
// Directed bench for gp_accum_blk: integer-arithmetic block model checked
// every cycle, plus literal expectations at the interesting points.
module tb_gp_accum_blk;
    localparam int DW   = 3;
    localparam int AW   = 6;
    localparam int CW   = 4;
    localparam int MAXV = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    bit   started = 1'b0;

    gp_accum_blk_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    gp_accum_blk #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: one block = m_len accepted samples, acc kept as a plain integer.
    int m_acc = 0, m_cnt = 0, m_len = 1, m_data = 0;
    bit m_sticky = 0, m_hold = 0, m_ovf = 0;
    int op_m, v_m;
    bit ov_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_len = 1; m_sticky = 0;
            m_hold = 0; m_data = 0; m_ovf = 0;
        end else if (m_hold) begin
            if (bus.i_ready) m_hold = 0;
        end else if (bus.i_clear) begin
            m_acc = 0; m_cnt = 0; m_sticky = 0;
        end else if (bus.i_valid) begin
            if (bus.i_sel == 2'd0)      op_m = int'(bus.i_data2);
            else if (bus.i_sel == 2'd1) op_m = int'(bus.i_data1) + int'(bus.i_data2);
            else if (bus.i_sel == 2'd2) op_m = int'(bus.i_data1);
            else                        op_m = 0;
            v_m  = bus.i_sub ? m_acc - op_m : m_acc + op_m;
            ov_m = (v_m > MAXV) || (v_m < 0);
            if (ov_m && bus.i_sat) v_m = (v_m < 0) ? 0 : MAXV;
            else                   v_m = v_m & MAXV;
            if (m_cnt == 0) m_len = (bus.i_len == 0) ? (1 << CW) : int'(bus.i_len);
            m_cnt++;
            m_sticky |= ov_m;
            if (m_cnt == m_len) begin
                m_data = v_m; m_ovf = m_sticky; m_hold = 1;
                m_acc = 0; m_cnt = 0; m_sticky = 0;
            end else begin
                m_acc = v_m;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            nvec++;
            if (int'(bus.o_acc) != m_acc || bus.o_ready != !m_hold || bus.o_valid != m_hold ||
                int'(bus.o_data) != m_data || bus.o_overflow != m_ovf) begin
                nerr++;
                $display("FAIL cycle t=%0t: acc=%0d/%0d rdy=%0b/%0b vld=%0b/%0b data=%0d/%0d ovf=%0b/%0b (dut/model)",
                         $time, bus.o_acc, m_acc, bus.o_ready, !m_hold, bus.o_valid, m_hold,
                         bus.o_data, m_data, bus.o_overflow, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input int a, input int b, input logic [1:0] sel,
                       input logic sub, input logic sat, input int len,
                       input logic clr, input logic rdy);
        bus.i_valid = v;
        bus.i_data1 = DW'(a);
        bus.i_data2 = DW'(b);
        bus.i_sel   = sel;
        bus.i_sub   = sub;
        bus.i_sat   = sat;
        bus.i_len   = CW'(len);
        bus.i_clear = clr;
        bus.i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 0, 1'b0, rdy);
    endtask

    task automatic blk(input int n, input int a, input int b, input logic [1:0] sel,
                       input logic sub, input logic sat, input int len);
        for (int i = 0; i < n; i++) cyc(1'b1, a, b, sel, sub, sat, len, 1'b0, 1'b0);
    endtask

    task automatic take();
        int n;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            idle(1'b0);
            n++;
        end
        chk("result_wait", int'(bus.o_valid), 1);
        idle(1'b1);
        chk("handshake_done", int'(bus.o_valid), 0);
    endtask

    task automatic chk_res(input string name, input int data, input int ovf);
        chk({name, "_valid"}, int'(bus.o_valid), 1);
        chk({name, "_data"}, int'(bus.o_data), data);
        chk({name, "_ovf"}, int'(bus.o_overflow), ovf);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_acc"}, int'(bus.o_acc), 0);
        chk({name, "_valid"}, int'(bus.o_valid), 0);
        chk({name, "_data"}, int'(bus.o_data), 0);
        chk({name, "_ovf"}, int'(bus.o_overflow), 0);
        chk({name, "_ready"}, int'(bus.o_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_valid = 0; bus.i_data1 = 0; bus.i_data2 = 0; bus.i_sel = 0;
        bus.i_sub = 0; bus.i_sat = 0; bus.i_len = 0; bus.i_clear = 0; bus.i_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        started = 1'b1;
        chk_reset("post_reset");

        // 4 x (7+7) = 56, no overflow
        blk(4, 7, 7, 2'b01, 1'b0, 1'b0, 4);
        chk_res("wrap56", 56, 0);
        chk("hold_not_ready", int'(bus.o_ready), 0);
        take();

        // 5 x 14 = 70: wraps to 6, saturates to 63
        blk(5, 7, 7, 2'b01, 1'b0, 1'b0, 5);
        chk_res("wrap_ovf", 6, 1);
        take();
        blk(5, 7, 7, 2'b01, 1'b0, 1'b1, 5);
        chk_res("sat_ovf", 63, 1);
        take();
        blk(4, 7, 7, 2'b01, 1'b0, 1'b0, 4);
        chk_res("sticky_cleared", 56, 0);
        take();

        // 0 - 5 - 5: wraps to 54, saturates to 0
        blk(2, 5, 0, 2'b10, 1'b1, 1'b0, 2);
        chk_res("sub_wrap", 54, 1);
        take();
        blk(2, 5, 0, 2'b10, 1'b1, 1'b1, 2);
        chk_res("sub_sat", 0, 1);
        take();

        // Backpressure with len = 1
        blk(1, 0, 3, 2'b00, 1'b0, 1'b0, 1);
        chk_res("len1", 3, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, i, i + 1, 2'b00, 1'b0, 1'b0, 1, 1'b0, 1'b0);
            chk("bp_ready", int'(bus.o_ready), 0);
            chk("bp_data", int'(bus.o_data), 3);
        end
        cyc(1'b1, 0, 6, 2'b00, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        chk("bp_released", int'(bus.o_valid), 0);
        chk("bp_acc", int'(bus.o_acc), 0);
        blk(1, 0, 5, 2'b00, 1'b0, 1'b0, 1);
        chk_res("bp_next", 5, 0);
        take();

        // Clear discards partial block and the concurrent sample
        blk(2, 0, 4, 2'b00, 1'b0, 1'b0, 3);
        chk("clr_pre", int'(bus.o_acc), 8);
        cyc(1'b1, 0, 4, 2'b00, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        chk("clr_acc", int'(bus.o_acc), 0);
        blk(3, 0, 2, 2'b00, 1'b0, 1'b0, 3);
        chk_res("clr_block", 6, 0);
        take();

        // i_len = 0 -> 16 samples; sel 11 counts zero samples
        blk(15, 0, 1, 2'b00, 1'b0, 1'b0, 0);
        chk("len0_pending", int'(bus.o_valid), 0);
        blk(1, 3, 3, 2'b11, 1'b0, 1'b0, 0);
        chk_res("len0", 15, 0);
        take();

        // i_len change mid-block is ignored
        blk(1, 0, 1, 2'b00, 1'b0, 1'b0, 3);
        blk(1, 0, 1, 2'b00, 1'b0, 1'b0, 2);
        chk("len_latch_pending", int'(bus.o_valid), 0);
        blk(1, 0, 1, 2'b00, 1'b0, 1'b0, 2);
        chk_res("len_latch", 3, 0);
        take();

        // Async reset mid-block
        blk(2, 0, 4, 2'b00, 1'b0, 1'b0, 4);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_midblock");
        @(posedge clk); #1 rst_n = 1'b1;

        // Async reset while holding a result
        blk(1, 0, 7, 2'b00, 1'b0, 1'b0, 1);
        chk_res("pre_rst_hold", 7, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        blk(2, 7, 7, 2'b01, 1'b0, 1'b0, 2);
        chk_res("after_rst", 28, 0);
        take();
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
